// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: parity-mode encodings,
// transmitter FSM states and the data-bit clamp helper.
package uart_pkg;

  // parity_mode encodings
  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;
  localparam logic [1:0] ParMark = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clamp a requested data-bit count into 5..max_bits.
  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int unsigned max_bits);
    if (req < 4'd5) begin
      return 4'd5;
    end
    if (32'(req) > max_bits) begin
      return 4'(max_bits);
    end
    return req;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..div_i while run_i is high and asserts tick_o on the last cycle of
// each bit period, wrapping back to 0. Held at 0 while idle or when loaded.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   run_i   : a frame is in progress
//   load_i  : frame accepted this cycle, restart the period
//   div_i   : latched divisor D (bit period = D+1 cycles)
//   tick_o  : current cycle ends a bit period
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == div_i);
  assign tick_o = run_i && at_end;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (load_i || !run_i || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: serialises one configurable frame per accept
// (start bit, 5..DATA_W data bits LSB first, optional parity, 1 or 2 stops).
//   Clk, Rst     : clock, asynchronous active-high reset
//   tx_data      : payload; tx_valid/tx_ready handshake accepts a frame
//   data_bits    : requested data bits (clamped to 5..DATA_W)
//   parity_mode  : none / even / odd / mark
//   two_stop     : two stop bits when set
//   baud_div     : bit period is baud_div+1 cycles
//   Rs232_Tx     : registered serial line, idle high
//   Tx_Done      : one-cycle pulse on the edge the frame completes
//   uart_state   : high while a frame is in flight
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        data_bits,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              Rs232_Tx,
  output logic              Tx_Done,
  output logic              uart_state
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bits_q, bits_d;
  logic [3:0]        idx_q, idx_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              line_q, line_d;
  logic              done_q, done_d;

  logic              accept;
  logic              run;
  logic              tick;
  logic [3:0]        nbits_in;
  logic              par_xor;
  logic              par_in;

  assign tx_ready   = (state_q == StIdle);
  assign accept     = tx_valid && tx_ready;
  assign run        = (state_q != StIdle);
  assign uart_state = run;
  assign Rs232_Tx   = line_q;
  assign Tx_Done    = done_q;

  assign nbits_in = clamp_bits(data_bits, DATA_W);

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    par_xor = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < int'(nbits_in)) begin
        par_xor = par_xor ^ tx_data[i];
      end
    end
  end

  always_comb begin
    unique case (parity_mode)
      ParEven: par_in = par_xor;
      ParOdd:  par_in = ~par_xor;
      ParMark: par_in = 1'b1;
      default: par_in = 1'b0;
    endcase
  end

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .run_i  (run),
    .load_i (accept),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    div_d      = div_q;
    line_d     = line_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        if (accept) begin
          state_d    = StStart;
          line_d     = 1'b0;
          shift_d    = tx_data;
          bits_d     = nbits_in;
          par_en_d   = (parity_mode != ParNone);
          par_bit_d  = par_in;
          two_stop_d = two_stop;
          stop_cnt_d = 1'b0;
          div_d      = baud_div;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = bits_q - 4'd1;  // bits still to send after this one
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q != 4'd0) begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q - 4'd1;
          end else if (par_en_q) begin
            state_d = StParity;
            line_d  = par_bit_q;
          end else begin
            state_d    = StStop;
            line_d     = 1'b1;
            stop_cnt_d = two_stop_q;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d    = StStop;
          line_d     = 1'b1;
          stop_cnt_d = two_stop_q;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_cnt_q) begin
            stop_cnt_d = 1'b0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bits_q     <= '0;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: a frame-level model predicts the
// line and status outputs every cycle; directed cases pin literal frames.
module tb_uart_frame_tx;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [3:0]  data_bits = '0;
  logic [1:0]  parity_mode = '0;
  logic        two_stop = 1'b0;
  logic [15:0] baud_div = '0;
  logic        Rs232_Tx;
  logic        Tx_Done;
  logic        uart_state;

  int n_pass = 0;
  int n_total = 0;

  uart_frame_tx #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .baud_div    (baud_div),
    .Rs232_Tx    (Rs232_Tx),
    .Tx_Done     (Tx_Done),
    .uart_state  (uart_state)
  );

  always #5 Clk = ~Clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  // Frame bits in transmit order, bit 0 = start bit; n = frame length in bits.
  function automatic void build_frame(input logic [7:0] d, input logic [3:0] db,
                                      input logic [1:0] pm, input logic ts,
                                      output logic [15:0] frm, output int n);
    int nb;
    logic p;
    nb = int'(db);
    if (nb < 5) nb = 5;
    if (nb > 8) nb = 8;
    frm = 16'hFFFF;
    frm[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      frm[1+i] = d[i];
      p = p ^ d[i];
    end
    n = 1 + nb;
    if (pm != 2'b00) begin
      frm[n] = (pm == 2'b01) ? p : ((pm == 2'b10) ? ~p : 1'b1);
      n++;
    end
    n = n + (ts ? 2 : 1);
  endfunction

  // Model state
  logic [15:0] m_frame = '1;
  int          m_n = 0;
  int          m_period = 1;
  int          m_k = 0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;

  initial forever begin
    @(posedge Clk);
    if (Rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == m_n * m_period) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (tx_valid) begin
        build_frame(tx_data, data_bits, parity_mode, two_stop, m_frame, m_n);
        m_period = int'(baud_div) + 1;
        m_k      = 0;
        m_active = 1'b1;
      end
    end
  end

  initial forever begin
    logic e_line, e_ready, e_busy, e_done;
    @(negedge Clk);
    if (Rst || !m_active) begin
      e_line  = 1'b1;
      e_ready = 1'b1;
      e_busy  = 1'b0;
      e_done  = Rst ? 1'b0 : m_done;
    end else begin
      e_line  = m_frame[m_k / m_period];
      e_ready = 1'b0;
      e_busy  = 1'b1;
      e_done  = 1'b0;
    end
    chk1("cyc_line", Rs232_Tx, e_line);
    chk1("cyc_ready", tx_ready, e_ready);
    chk1("cyc_busy", uart_state, e_busy);
    chk1("cyc_done", Tx_Done, e_done);
  end

  task automatic directed(input string name, input logic [7:0] d, input logic [3:0] db,
                          input logic [1:0] pm, input logic ts, input logic [15:0] div,
                          input string exp_frame, input int exp_done);
    string obs;
    int    per;
    int    done_at;
    per = int'(div) + 1;
    obs = "";
    done_at = -1;
    @(posedge Clk);
    #1;
    tx_data = d; data_bits = db; parity_mode = pm; two_stop = ts; baud_div = div;
    tx_valid = 1'b1;
    @(posedge Clk);  // E0
    #1;
    tx_valid = 1'b0;
    // Scramble inputs; the frame in flight must not notice.
    tx_data = 8'($urandom); data_bits = 4'($urandom); parity_mode = 2'($urandom);
    two_stop = 1'($urandom); baud_div = 16'($urandom_range(0, 5));
    for (int k = 0; k < 400; k++) begin
      @(negedge Clk);
      if ((k % per) == 0 && obs.len() < exp_frame.len()) obs = {obs, Rs232_Tx ? "1" : "0"};
      if (Tx_Done) begin
        done_at = k;
        break;
      end
      @(posedge Clk);
    end
    chk_str({name, "_frame"}, obs, exp_frame);
    chk_int({name, "_done_cycle"}, done_at, exp_done);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      if (Tx_Done) begin
        got = 1'b1;
        break;
      end
    end
    chk1(name, got, 1'b1);
  endtask

  initial begin
    logic [15:0] frm;
    int          n;
    int          dones;

    // Pin the model against hand-computed frames.
    build_frame(8'hA5, 4'd8, 2'b00, 1'b0, frm, n);
    chk_int("model_a5_len", n, 10);
    chk_int("model_a5_bits", int'(frm[9:0]), 10'b1101001010);
    build_frame(8'h12, 4'd2, 2'b11, 1'b0, frm, n);
    chk_int("model_clamp_len", n, 8);

    #1 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk1("rst_line", Rs232_Tx, 1'b1);
    chk1("rst_ready", tx_ready, 1'b1);
    chk1("rst_busy", uart_state, 1'b0);
    chk1("rst_done", Tx_Done, 1'b0);
    Rst = 1'b0;

    directed("a5_8n1_d3", 8'hA5, 4'd8, 2'b00, 1'b0, 16'd3, "0101001011", 40);
    directed("07_8e2_d0", 8'h07, 4'd8, 2'b01, 1'b1, 16'd0, "011100000111", 12);
    directed("55_7o1_d1", 8'h55, 4'd7, 2'b10, 1'b0, 16'd1, "0101010111", 20);
    directed("12_db2_mark", 8'h12, 4'd2, 2'b11, 1'b0, 16'd0, "00100111", 8);
    directed("ff_db12_8n1", 8'hFF, 4'd12, 2'b00, 1'b0, 16'd0, "0111111111", 10);

    // Back-to-back with tx_valid held high.
    @(posedge Clk);
    #1;
    tx_data = 8'h3C; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    baud_div = 16'd2; tx_valid = 1'b1;
    wait_done("b2b_first_done");
    chk1("b2b_idle_cycle_line", Rs232_Tx, 1'b1);
    @(negedge Clk);
    chk1("b2b_next_start", Rs232_Tx, 1'b0);
    chk1("b2b_next_busy", uart_state, 1'b1);
    tx_valid = 1'b0;
    wait_done("b2b_second_done");

    // Reset at E0+10 of an 8N1 frame.
    @(posedge Clk);
    #1;
    tx_data = 8'hA5; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    baud_div = 16'd3; tx_valid = 1'b1;
    @(posedge Clk);  // E0
    #1 tx_valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk1("midrst_line", Rs232_Tx, 1'b1);
    chk1("midrst_done", Tx_Done, 1'b0);
    chk1("midrst_busy", uart_state, 1'b0);
    chk1("midrst_ready", tx_ready, 1'b1);
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;
    dones = 0;
    n = 0;
    repeat (60) begin
      @(negedge Clk);
      if (Tx_Done) dones++;
      if (!Rs232_Tx) n++;
    end
    chk_int("midrst_no_done", dones, 0);
    chk_int("midrst_line_low_cycles", n, 0);

    // Randomised traffic, including tx_valid while busy.
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clk);
      #1;
      tx_valid    = ($urandom_range(0, 3) == 0);
      tx_data     = 8'($urandom);
      data_bits   = 4'($urandom);
      parity_mode = 2'($urandom);
      two_stop    = 1'($urandom);
      baud_div    = 16'($urandom_range(0, 3));
    end
    tx_valid = 1'b0;
    repeat (80) @(posedge Clk);
    @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
